pulse_gate_ctrl: RTL and testbench

- Measurement-window controller that sequences one downstream pulse counter with an enable-gated, clear-on-disable 16-bit count.
- Opens a programmable gate of N clock cycles, captures the counter value at gate close, flags wrap-around, and presents the result through a valid/ready handshake.
- Supports single-shot and continuous (back-to-back) measurement, and abort.
- Sits between the control/register side and the pulse counter.

---
 rtl/pulse_gate_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pulse_gate_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gate_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_gate_ctrl
// Measurement-window controller for one downstream pulse counter. The counter
// counts while o_cnt_en is high and clears itself while o_cnt_en is low.
// A start request opens a gate of i_gate_len cycles; at gate close the counter
// value is captured together with a wrap-around flag and a sequence number,
// and offered to the consumer through a valid/ready handshake. Continuous mode
// re-arms after each accepted result; i_abort drops everything back to IDLE.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_start            one-cycle start request (honoured in IDLE only)
//   i_continuous       re-arm automatically after each accepted result
//   i_abort            terminate the running measurement
//   i_gate_len         gate length in cycles, sampled on start / re-arm
//   o_cnt_en           counter enable (low clears the counter)
//   i_pulse_cnt        current counter value
//   o_busy             controller is not idle
//   o_result           captured count
//   o_overflow         counter wrapped during the gate of this result
//   o_meas_id          sequence number of the presented result
//   o_result_valid     result available
//   i_result_ready     consumer accepts the result
//   o_err_cfg          one-cycle pulse: start rejected, gate length zero
// -----------------------------------------------------------------------------
module pulse_gate_ctrl #(
    parameter int GATE_W = 24,
    parameter int CNT_W  = 16,
    parameter int ID_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic [GATE_W-1:0] i_gate_len,
    output logic              o_cnt_en,
    input  logic [CNT_W-1:0]  i_pulse_cnt,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_result,
    output logic              o_overflow,
    output logic [ID_W-1:0]   o_meas_id,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_err_cfg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_GATE    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ZERO = GATE_W'(0);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [ID_W-1:0]   ID_ZERO   = ID_W'(0);
    localparam logic [ID_W-1:0]   ID_ONE    = ID_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic                load_len_s;
    logic                err_s;
    logic                len_zero_s;
    logic                handshake_s;
    logic [GATE_W-1:0]   gate_cnt_r;
    logic [CNT_W-1:0]    prev_cnt_r;
    logic                ovf_trk_r;
    logic [CNT_W-1:0]    result_r;
    logic                overflow_r;
    logic [ID_W-1:0]     meas_id_r;
    logic                cnt_en_r;
    logic                busy_r;
    logic                valid_r;
    logic                err_cfg_r;

    assign len_zero_s  = (i_gate_len == GATE_ZERO);
    assign handshake_s = valid_r & i_result_ready;

    // Next-state logic; abort wins over everything outside IDLE.
    always_comb begin
        state_s    = state_r;
        load_len_s = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A coincident abort cancels the start request.
                if (i_start && !i_abort) begin
                    if (len_zero_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s    = ST_ARM;
                        load_len_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GATE;
                end
            end
            ST_GATE: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (gate_cnt_r == GATE_ONE) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_GATE;
                end
            end
            ST_CAPTURE: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (handshake_s) begin
                    if (i_continuous && !len_zero_s) begin
                        state_s    = ST_ARM;
                        load_len_s = 1'b1;
                    end else if (i_continuous) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and outputs decoded from the next state so they are registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            err_cfg_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_en_r  <= (state_s == ST_GATE);
            busy_r    <= (state_s != ST_IDLE);
            valid_r   <= (state_s == ST_DONE);
            err_cfg_r <= err_s;
        end
    end

    // Gate length counter: loaded on start/re-arm, counts down while the gate is open.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            gate_cnt_r <= GATE_ZERO;
        end else if (load_len_s) begin
            gate_cnt_r <= i_gate_len;
        end else if (state_r == ST_GATE) begin
            gate_cnt_r <= gate_cnt_r - GATE_ONE;
        end else begin
            gate_cnt_r <= gate_cnt_r;
        end
    end

    // Wrap tracker: a count lower than the previous one during the gate means a wrap.
    // Previous value starts at zero because the counter is cleared during ARM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_cnt_r <= CNT_ZERO;
            ovf_trk_r  <= 1'b0;
        end else if (state_r == ST_ARM) begin
            prev_cnt_r <= CNT_ZERO;
            ovf_trk_r  <= 1'b0;
        end else if (state_r == ST_GATE) begin
            prev_cnt_r <= i_pulse_cnt;
            ovf_trk_r  <= ovf_trk_r | (i_pulse_cnt < prev_cnt_r);
        end else begin
            prev_cnt_r <= prev_cnt_r;
            ovf_trk_r  <= ovf_trk_r;
        end
    end

    // Result capture at gate close; skipped when the capture cycle is aborted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            result_r   <= CNT_ZERO;
            overflow_r <= 1'b0;
            meas_id_r  <= ID_ZERO;
        end else if ((state_r == ST_CAPTURE) && (state_s == ST_DONE)) begin
            result_r   <= i_pulse_cnt;
            overflow_r <= ovf_trk_r;
            meas_id_r  <= meas_id_r + ID_ONE;
        end else begin
            result_r   <= result_r;
            overflow_r <= overflow_r;
            meas_id_r  <= meas_id_r;
        end
    end

    assign o_cnt_en       = cnt_en_r;
    assign o_busy         = busy_r;
    assign o_result       = result_r;
    assign o_overflow     = overflow_r;
    assign o_meas_id      = meas_id_r;
    assign o_result_valid = valid_r;
    assign o_err_cfg      = err_cfg_r;

endmodule

// File: tb/tb_pulse_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulse_gate_ctrl
// Bench for pulse_gate_ctrl with a behavioural pulse counter (clear while the
// enable is low, optional preload value, rising-edge counting). Stimulus pushes
// the expected result records into a queue; a monitor pops and compares on
// every accepted handshake. Timing and control checks are done inline.
// -----------------------------------------------------------------------------
module tb_pulse_gate_ctrl;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic [7:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic        abort;
    logic [23:0] gate_len;
    logic        cnt_en;
    logic [15:0] pulse_cnt;
    logic        busy;
    logic [15:0] result;
    logic        overflow;
    logic [7:0]  meas_id;
    logic        valid;
    logic        ready;
    logic        err_cfg;

    // counter model and pulse generator state
    logic        pulse = 1'b0;
    logic        pulse_d = 1'b0;
    logic [15:0] preload = 16'd0;
    logic [15:0] cnt_model = 16'd0;
    int          rel = 0;
    int          gen_np = 0;
    int          gen_per = 0;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_id = 8'd0;

    pulse_gate_ctrl #(.GATE_W(24), .CNT_W(16), .ID_W(8)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_continuous   (continuous),
        .i_abort        (abort),
        .i_gate_len     (gate_len),
        .o_cnt_en       (cnt_en),
        .i_pulse_cnt    (pulse_cnt),
        .o_busy         (busy),
        .o_result       (result),
        .o_overflow     (overflow),
        .o_meas_id      (meas_id),
        .o_result_valid (valid),
        .i_result_ready (ready),
        .o_err_cfg      (err_cfg)
    );

    always #5 clk = ~clk;

    assign pulse_cnt = cnt_model;

    // Downstream pulse counter: cleared (to the preload value) while disabled.
    always @(posedge clk) begin
        pulse_d <= pulse;
        if (!cnt_en) cnt_model <= preload;
        else if (pulse && !pulse_d) cnt_model <= cnt_model + 16'd1;
    end

    // Pulse pattern per window: pulses start at cycle 10, period 7, 4 cycles high.
    function automatic logic in_win(int r, int np, int per);
        int p;
        if (r < 1 || per <= 0) return 1'b0;
        p = r % per;
        if (p < 10) return 1'b0;
        return (((p - 10) / 7) < np) && (((p - 10) % 7) < 4);
    endfunction

    // rel = cycle index relative to the edge that accepts the start.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rel = rel + 1;
            pulse = in_win(rel, gen_np, gen_per);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each accepted result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual id %0h result %0h expected none", meas_id, result);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 32'(result), 32'(e.res));
                    check("sb_overflow", 32'(overflow), 32'(e.ovf));
                    check("sb_meas_id", 32'(meas_id), 32'(e.id));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in cycle 1 (ARM).
    task automatic fire();
        step();
        start = 1'b1;
        rel = -1;
        step();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] res, input logic ovf);
        exp_t e;
        exp_id = exp_id + 8'd1;
        e.res = res;
        e.ovf = ovf;
        e.id  = exp_id;
        exp_q.push_back(e);
    endtask

    // Single-shot measurement with ready high; gate_len is disturbed mid-gate.
    task automatic run_single(input int n, input int np, input logic [15:0] pre,
                              input logic [15:0] exp_res, input logic exp_ovf);
        int en_cnt;
        int first_v;
        gate_len = 24'(n);
        gen_np = np;
        gen_per = n + 3;
        preload = pre;
        ready = 1'b1;
        continuous = 1'b0;
        push_exp(exp_res, exp_ovf);
        en_cnt = 0;
        first_v = -1;
        fire();
        for (int k = 1; k <= n + 4; k++) begin
            if (k > 1) step();
            if (k == n / 2) gate_len = 24'd1;
            @(negedge clk);
            if (cnt_en) en_cnt++;
            if (valid && first_v < 0) first_v = k;
            if (k == n + 4) begin
                check("valid_one_cycle", 32'(valid), 32'd0);
                check("busy_after_accept", 32'(busy), 32'd0);
            end
        end
        check("cnt_en_cycles", 32'(en_cnt), 32'(n));
        check("valid_latency", 32'(first_v), 32'(n + 3));
    endtask

    initial begin
        int en_cnt;
        int nv;
        int vpos[3];
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        abort = 1'b0;
        gate_len = 24'd0;
        ready = 1'b0;

        // reset state
        step(); step(); step();
        @(negedge clk);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_meas_id", 32'(meas_id), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err_cfg", 32'(err_cfg), 32'd0);
        step();
        rst_n = 1'b1;

        // single shot, 100-cycle gate, 10 pulses
        run_single(100, 10, 16'd0, 16'd10, 1'b0);

        // continuous, 50-cycle gate, 3 pulses per window, ready high
        gate_len = 24'd50;
        gen_np = 3;
        gen_per = 53;
        preload = 16'd0;
        ready = 1'b1;
        continuous = 1'b1;
        push_exp(16'd3, 1'b0);
        push_exp(16'd3, 1'b0);
        push_exp(16'd3, 1'b0);
        en_cnt = 0;
        nv = 0;
        fire();
        for (int k = 1; k <= 160; k++) begin
            if (k > 1) step();
            if (k == 107) continuous = 1'b0;
            @(negedge clk);
            if (k <= 159 && cnt_en) en_cnt++;
            if (valid) begin
                if (nv < 3) vpos[nv] = k;
                nv++;
            end
            if (k == 160) check("cont_idle_after_stop", 32'(busy), 32'd0);
        end
        check("cont_cnt_en_cycles", 32'(en_cnt), 32'd150);
        check("cont_valid_count", 32'(nv), 32'd3);
        for (int j = 0; j < 3; j++) check("cont_valid_period", 32'(vpos[j]), 32'(53 * (j + 1)));

        // ready held low for 20 cycles in DONE, then re-arm with gate_len 0
        gate_len = 24'd20;
        gen_np = 2;
        gen_per = 23;
        ready = 1'b0;
        continuous = 1'b1;
        push_exp(16'd2, 1'b0);
        fire();
        for (int k = 2; k <= 23; k++) step();
        @(negedge clk);
        check("hold_valid_rise", 32'(valid), 32'd1);
        bad = 0;
        for (int k = 23; k <= 42; k++) begin
            if (k > 23) step();
            @(negedge clk);
            if (!(valid && result == 16'd2 && meas_id == exp_id && !cnt_en && busy)) bad++;
        end
        check("hold_stable_cycles", 32'(bad), 32'd0);
        step();
        ready = 1'b1;
        gate_len = 24'd0;
        step();
        @(negedge clk);
        check("rearm_zero_err", 32'(err_cfg), 32'd1);
        check("rearm_zero_busy", 32'(busy), 32'd0);
        check("rearm_zero_valid", 32'(valid), 32'd0);
        continuous = 1'b0;

        // wrap: preload near the top, then a clean follow-up
        run_single(60, 5, 16'hFFFD, 16'h0002, 1'b1);
        run_single(60, 5, 16'h0000, 16'h0005, 1'b0);

        // abort mid-gate
        gate_len = 24'd100;
        gen_np = 0;
        gen_per = 103;
        ready = 1'b1;
        fire();
        for (int k = 1; k <= 50; k++) begin
            if (k > 1) step();
            @(negedge clk);
        end
        check("abort_gate_open", 32'(cnt_en), 32'd1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_cnt_en", 32'(cnt_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 110; k++) step();
        @(negedge clk);
        check("abort_meas_id", 32'(meas_id), 32'(exp_id));

        // start with zero gate length
        step();
        gate_len = 24'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_len_err", 32'(err_cfg), 32'd1);
        check("zero_len_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        check("zero_len_err_once", 32'(err_cfg), 32'd0);

        // start coincident with abort in IDLE is cancelled
        step();
        gate_len = 24'd5;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 32'(busy), 32'd0);

        // reset during DONE with valid high
        gate_len = 24'd10;
        gen_np = 0;
        gen_per = 13;
        ready = 1'b0;
        fire();
        for (int k = 2; k <= 13; k++) step();
        @(negedge clk);
        check("rst_done_valid", 32'(valid), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_cnt_en", 32'(cnt_en), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_result", 32'(result), 32'd0);
        check("rst2_overflow", 32'(overflow), 32'd0);
        check("rst2_meas_id", 32'(meas_id), 32'd0);
        check("rst2_valid", 32'(valid), 32'd0);
        check("rst2_err_cfg", 32'(err_cfg), 32'd0);
        exp_id = 8'd0;
        run_single(10, 1, 16'd0, 16'd1, 1'b0);

        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
